// File: rtl/sreg_pkg.sv
// Shared types and lane-latency helper for the multi-lane skew/deskew delay line.
package sreg_pkg;

  typedef enum logic {SKEW, DESKEW} mode_e;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // Lane k latency in shift cycles; SKEW grows with k, DESKEW shrinks with k.
  function automatic int unsigned lane_delay(mode_e mode, int unsigned base,
                                             int unsigned n_ch, int unsigned k);
    return (mode == SKEW) ? base + k : base + n_ch - 1 - k;
  endfunction

endpackage

// File: rtl/sreg_lane.sv
// One valid-tracked delay chain of DEPTH stages; invalid stages always carry zero data.
module sreg_lane #(
  parameter int unsigned D_W   = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shift_en,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [D_W-1:0] data_in,
  output logic [D_W-1:0] data_out,
  output logic           out_valid,
  output logic           busy
);

  logic [DEPTH-1:0]          vld_q, vld_d;
  logic [DEPTH-1:0][D_W-1:0] dat_q, dat_d;
  logic [D_W-1:0]            head;

  assign head = in_valid ? data_in : '0;

  if (DEPTH == 1) begin : g_one
    assign vld_d = in_valid;
    assign dat_d = head;
  end else begin : g_chain
    assign vld_d = {vld_q[DEPTH-2:0], in_valid};
    assign dat_d = {dat_q[DEPTH-2:0], head};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (clear) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (shift_en) begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign data_out  = dat_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];
  assign busy      = |vld_q;

endmodule

// File: rtl/sreg_skew.sv
// Multi-lane delay line with per-lane fixed latency and burst-drain tracking.
module sreg_skew
  import sreg_pkg::*;
#(
  parameter int unsigned D_W  = 32,
  parameter int unsigned N_CH = 4,
  parameter int unsigned BASE = 1,
  parameter mode_e       MODE = SKEW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                clear,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [N_CH*D_W-1:0] data_in,
  output logic [N_CH*D_W-1:0] data_out,
  output logic [N_CH-1:0]     out_valid,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LMax = BASE + N_CH - 1;
  localparam int unsigned CntW = $clog2(LMax + 1);
  // Accept edge is the first of LMax shifts, so LMax-1 further shifts remain.
  localparam logic [CntW-1:0] CntLoad = CntW'(LMax - 1);

  logic [N_CH-1:0] lane_busy;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    localparam int unsigned Depth = lane_delay(MODE, BASE, N_CH, $unsigned(k));
    sreg_lane #(
      .D_W   (D_W),
      .DEPTH (Depth)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .shift_en  (shift_en),
      .clear     (clear),
      .in_valid  (in_valid),
      .data_in   (data_in[k*D_W +: D_W]),
      .data_out  (data_out[k*D_W +: D_W]),
      .out_valid (out_valid[k]),
      .busy      (lane_busy[k])
    );
  end

  assign busy = |lane_busy;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            accept;

  assign accept = shift_en & in_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept && in_last) begin
      if (LMax == 1) begin
        // Single-stage longest lane: the last token is already on the output.
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = DRAIN;
        cnt_d   = CntLoad;
      end
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (shift_en && state_q == DRAIN) begin
      if (cnt_q == CntW'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_sreg_skew.sv
// Bench for sreg_skew: SKEW and DESKEW instances share stimulus and a history-based model.
module tb_sreg_skew;
  import sreg_pkg::*;

  localparam int D_W  = 32;
  localparam int N_CH = 4;
  localparam int BASE = 1;
  localparam int LMAX = BASE + N_CH - 1;
  localparam int W    = N_CH * D_W;

  logic         clk = 1'b0;
  logic         rst, shift_en, clear, in_valid, in_last;
  logic [W-1:0] data_in;
  logic [W-1:0] do_s, do_d;
  logic [N_CH-1:0] ov_s, ov_d;
  logic         busy_s, busy_d, done_s, done_d;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sreg_skew #(.D_W(D_W), .N_CH(N_CH), .BASE(BASE), .MODE(SKEW)) u_skew (
    .clk(clk), .rst(rst), .shift_en(shift_en), .clear(clear), .in_valid(in_valid),
    .in_last(in_last), .data_in(data_in), .data_out(do_s), .out_valid(ov_s),
    .busy(busy_s), .done(done_s)
  );

  sreg_skew #(.D_W(D_W), .N_CH(N_CH), .BASE(BASE), .MODE(DESKEW)) u_deskew (
    .clk(clk), .rst(rst), .shift_en(shift_en), .clear(clear), .in_valid(in_valid),
    .in_last(in_last), .data_in(data_in), .data_out(do_d), .out_valid(ov_d),
    .busy(busy_d), .done(done_d)
  );

  // Model: history of shift-edge inputs, newest first; a lane of latency L shows entry L-1.
  typedef struct packed {
    logic         v;
    logic         l;
    logic [W-1:0] d;
  } tok_t;

  tok_t hist[$];
  tok_t m_tok;
  bit   m_done = 1'b0;

  function automatic bit last_reached();
    if (hist.size() < LMAX) return 1'b0;
    if (!(hist[LMAX-1].v && hist[LMAX-1].l)) return 1'b0;
    for (int i = 0; i < LMAX - 1; i++) if (hist[i].v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_busy();
    foreach (hist[i]) if (hist[i].v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void expect_out(input bit desk, output logic [N_CH-1:0] ev,
                                     output logic [W-1:0] ed);
    ev = '0;
    ed = '0;
    for (int k = 0; k < N_CH; k++) begin
      int l;
      l = desk ? BASE + N_CH - 1 - k : BASE + k;
      if (hist.size() >= l && hist[l-1].v) begin
        ev[k] = 1'b1;
        ed[k*D_W +: D_W] = hist[l-1].d[k*D_W +: D_W];
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      hist.delete();
      m_done = 1'b0;
    end else if (shift_en) begin
      m_tok.v = in_valid;
      m_tok.l = in_last;
      m_tok.d = in_valid ? data_in : '0;
      hist.push_front(m_tok);
      if (hist.size() > LMAX) void'(hist.pop_back());
      m_done = last_reached();
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  logic [N_CH-1:0] ev;
  logic [W-1:0]    ed;

  always @(negedge clk) begin
    if (chk_en) begin
      expect_out(1'b0, ev, ed);
      chk("cyc_valid_skew", W'(ov_s), W'(ev));
      chk("cyc_data_skew", do_s, ed);
      expect_out(1'b1, ev, ed);
      chk("cyc_valid_deskew", W'(ov_d), W'(ev));
      chk("cyc_data_deskew", do_d, ed);
      chk("cyc_busy_skew", W'(busy_s), W'(m_busy()));
      chk("cyc_busy_deskew", W'(busy_d), W'(m_busy()));
      chk("cyc_done_skew", W'(done_s), W'(m_done));
      chk("cyc_done_deskew", W'(done_d), W'(m_done));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic se, input logic v, input logic l, input logic [W-1:0] d);
    shift_en = se;
    in_valid = v;
    in_last  = l;
    data_in  = d;
  endtask

  logic [W-1:0] tok10, tok_a;

  initial begin
    tok10 = {32'h13, 32'h12, 32'h11, 32'h10};
    tok_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    rst = 1'b0;
    clear = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    tick(2);
    chk("reset_valid", W'(ov_s), '0);
    chk("reset_data", do_s, '0);
    chk("reset_busy", W'(busy_s), '0);
    chk("reset_done", W'(done_s), '0);
    rst = 1'b1;
    tick(1);

    // Single-token burst, free-running shift.
    drive(1'b1, 1'b1, 1'b1, tok10);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("t1_lane0_valid", W'(ov_s), W'(4'b0001));
    chk("t1_lane0_data", W'(do_s[31:0]), W'(32'h10));
    tick(3);
    chk("t1_lane3_valid", W'(ov_s), W'(4'b1000));
    chk("t1_lane3_data", W'(do_s[127:96]), W'(32'h13));
    chk("t1_done", W'(done_s), W'(1'b1));
    tick(1);
    chk("t1_done_fall", W'(done_s), '0);
    chk("t1_busy_fall", W'(busy_s), '0);
    tick(2);

    // Same token, three stall cycles after accept.
    drive(1'b1, 1'b1, 1'b1, tok10);
    tick(1);
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("t2_lane0_valid", W'(ov_s), W'(4'b0001));
    tick(2);
    chk("t2_hold_valid", W'(ov_s), W'(4'b0001));
    chk("t2_hold_data", W'(do_s[31:0]), W'(32'h10));
    tick(1);
    shift_en = 1'b1;
    tick(3);
    chk("t2_lane3_valid", W'(ov_s), W'(4'b1000));
    chk("t2_lane3_data", W'(do_s[127:96]), W'(32'h13));
    chk("t2_done", W'(done_s), W'(1'b1));
    tick(2);

    // Burst 1..8 with in_last on 8.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b1, i == 8, {4{32'(i)}});
      tick(1);
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    tick(3);
    chk("t3_lane3_data", W'(do_s[127:96]), W'(32'd8));
    chk("t3_done", W'(done_s), W'(1'b1));
    chk("t3_busy", W'(busy_s), W'(1'b1));
    tick(1);
    chk("t3_busy_fall", W'(busy_s), '0);
    chk("t3_done_fall", W'(done_s), '0);
    tick(1);

    // Flush while lanes hold 3..6; the input on the clear edge is discarded.
    for (int i = 3; i <= 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, {4{32'(i)}});
      tick(1);
    end
    clear = 1'b1;
    drive(1'b1, 1'b1, 1'b1, {4{32'h77}});
    tick(1);
    clear = 1'b0;
    chk("t4_valid", W'(ov_s), '0);
    chk("t4_data", do_s, '0);
    chk("t4_busy", W'(busy_s), '0);
    chk("t4_done", W'(done_s), '0);
    drive(1'b1, 1'b1, 1'b1, tok10);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("t4_new_lane0", W'(do_s[31:0]), W'(32'h10));
    tick(5);

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 1'b1, 1'b1, tok10);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0);
    tick(1);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid_s", W'(ov_s), '0);
    chk("t5_valid_d", W'(ov_d), '0);
    chk("t5_data", do_s, '0);
    chk("t5_busy", W'(busy_s), '0);
    tick(1);
    #3 rst = 1'b1;
    tick(6);
    drive(1'b1, 1'b1, 1'b0, tok10);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("t5_resume_lane0", W'(do_s[31:0]), W'(32'h10));
    tick(4);

    // DESKEW instance: lane3 first, lane0 last and carries done.
    drive(1'b1, 1'b1, 1'b1, tok_a);
    tick(1);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("t6_lane3_valid", W'(ov_d), W'(4'b1000));
    chk("t6_lane3_data", W'(do_d[127:96]), W'(32'hA3));
    tick(3);
    chk("t6_lane0_valid", W'(ov_d), W'(4'b0001));
    chk("t6_lane0_data", W'(do_d[31:0]), W'(32'hA0));
    chk("t6_done", W'(done_d), W'(1'b1));
    tick(2);

    // Mixed traffic with stalls, bursts and occasional flushes.
    for (int i = 0; i < 150; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            {$urandom, $urandom, $urandom, $urandom});
      clear = ($urandom_range(0, 31) == 0);
      tick(1);
    end
    clear = 1'b0;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
